de_issue_stage: RTL and testbench
=================================

Name: de_issue_stage

Overview:
Parametrised decode/issue stage. It performs N-source operand forwarding on both rs1 and rs2, detects load-use hazards, and holds off issue while a control-transfer instruction is unresolved. It also owns the DE->EXE pipeline register with valid, hold and flush control. It sits between the register-file read and execute, and takes its pre-decoded immediate from the immediate generator.

Parameters:
XLEN, 64, datapath width.
NUM_FWD, 3, number of forwarding sources; index 0 is the youngest (EXE), the highest index is the oldest (WB).
CTRL_WAIT, 1, 1 = stall issue after a branch/JAL/JALR until it resolves; 0 = no control stall.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
de_v  input  1  DE instruction valid.
de_ir  input  32  DE instruction.
de_npc  input  XLEN  DE next-PC.
de_imm  input  XLEN  sign-extended immediate for de_ir.
rf_rs1_data  input  XLEN  register-file read for de_ir[19:15].
rf_rs2_data  input  XLEN  register-file read for de_ir[24:20].
fwd_v  input  NUM_FWD  per-source "writes a register" valid.
fwd_drid  input  5*NUM_FWD  per-source destination register, source k at bits [5k+4:5k].
fwd_data  input  XLEN*NUM_FWD  per-source result.
fwd_is_load  input  NUM_FWD  per-source "result not yet available" (load in flight).
br_resolve  input  1  EXE has resolved the outstanding control transfer.
flush  input  1  kill the DE and EXE contents.
ds_stall  input  1  downstream stall; hold the EXE register.
exe_v  output  1  EXE valid.
exe_ir  output  32  EXE instruction.
exe_npc  output  XLEN  EXE next-PC.
exe_op1  output  XLEN  ALU operand 1.
exe_op2  output  XLEN  ALU operand 2.
exe_rs2_val  output  XLEN  forwarded rs2 value (store data).
de_stall  output  1  DE cannot accept or advance; fetch must hold.
br_wait  output  1  FSM is in the BR_WAIT state.

Behaviour:
- Reset (asynchronous, active-low):
  - exe_v, exe_ir, exe_npc, exe_op1, exe_op2, exe_rs2_val are all 0.
  - FSM is IDLE; de_stall and br_wait are 0.
- Operand use, decoded from opcode de_ir[6:0]:
  - rs1 is used unless the opcode is 0110111, 0010111 or 1101111.
  - rs2 is used for 0110011, 0111011, 0100011 and 1100011.
- Forwarding is applied per operand and is combinational. Source k matches when all of the following hold:
  - fwd_v[k] = 1;
  - fwd_drid[k] equals the operand's register id;
  - the register id is not 0.
- Forwarding priority: the lowest matching index wins. With no match the operand takes the rf_* value. Register x0 always yields the rf value.
- Load-use hazard: asserted when the winning match for a used operand has fwd_is_load = 1. Older matches are not considered once a younger one wins.
- Operand 2 select:
  - exe_op2 takes the forwarded rs2 for 0110011, 0111011 and 1100011.
  - For all other opcodes it takes de_imm.
  - exe_rs2_val always takes the forwarded rs2.
- FSM, states IDLE and BR_WAIT:
  - IDLE -> BR_WAIT when CTRL_WAIT = 1 and a control opcode (1100011, 1101111, 1100111) issues into EXE.
  - BR_WAIT -> IDLE on br_resolve = 1 or flush = 1.
  - In BR_WAIT, br_wait = 1 and de_stall = 1.
- de_stall = (de_v & hazard) | (FSM in BR_WAIT) | ds_stall.
- Issue condition: de_v & !hazard & FSM in IDLE & !ds_stall & !flush.
- EXE register update each edge, in priority order:
  1. flush: exe_v <= 0; the other EXE fields are don't-care and are held.
  2. ds_stall: all EXE registers hold, including exe_v.
  3. Issue: exe_v <= 1 and all fields load. Latency is 1 cycle from DE to EXE.
  4. Otherwise, insert a bubble: exe_v <= 0, and exe_ir <= 32'h00000013 (NOP).
- Simultaneous events:
  - br_resolve in the same cycle as a new control instruction in DE: that instruction may not issue this cycle. It issues the next cycle and re-enters BR_WAIT.
  - flush combined with ds_stall: flush wins.
  - Hazard combined with BR_WAIT: a single bubble is issued per cycle; the two do not compound.
- Reset asserted mid-operation, including during BR_WAIT, returns the block to the IDLE/reset state immediately.

Test Plan:
1. Forwarding priority: x5 matches source 0 (data A) and source 2 (data B); issue ADD x1,x5,x5 (0x005280B3) -> next cycle exe_op1 = exe_op2 = A, exe_v = 1.
2. x0 is never forwarded: all sources have fwd_v = 1 and drid = 0; issue ADDI x1,x0,7 with rf_rs1_data = 0 -> exe_op1 = 0 and exe_op2 = 7.
3. Load-use: source 0 has drid = 5 and fwd_is_load = 1, DE holds ADD using x5 -> one cycle of exe_v = 0, exe_ir = 0x13, de_stall = 1. Dropping fwd_is_load -> the instruction issues with its fwd_data.
4. Branch wait: issue BEQ -> br_wait = 1 and de_stall = 1 for 3 cycles with exe_v = 0. Pulse br_resolve -> next cycle IDLE, and the following instruction issues.
5. Downstream hold: ds_stall = 1 for 2 cycles after an issue -> exe_* unchanged and exe_v stays 1. flush together with ds_stall -> exe_v = 0 on the next edge.
6. Reset mid BR_WAIT: reset low asynchronously -> all outputs 0 and br_wait = 0 before the next edge. After release, the first valid DE instruction issues in 1 cycle.

Source files
------------

// File: rtl/de_issue_stage.sv
// de_issue_stage
//
// Decode/issue stage that owns the DE->EXE pipeline register.
//   - Forwards operands for rs1 and rs2 from NUM_FWD bypass sources.
//     Index 0 is the youngest (EXE) source, and the lowest matching index wins.
//   - Detects load-use hazards when the winning source is still a load in flight.
//   - Optionally holds issue after a control transfer until EXE resolves it
//     (BR_WAIT state).
//
// Ports
//   CLK, reset            clock, asynchronous active-low reset
//   de_v, de_ir, de_npc   DE instruction valid / word / next-PC
//   de_imm                sign-extended immediate for de_ir
//   rf_rs1_data/rs2_data  register-file reads for rs1 / rs2
//   fwd_v/drid/data/is_load  per-source bypass bus (source k in slice k)
//   br_resolve            EXE resolved the outstanding control transfer
//   flush                 kill DE and EXE contents
//   ds_stall              downstream stall, hold the EXE register
//   exe_*                 EXE pipeline register outputs
//   de_stall              DE cannot advance; fetch must hold
//   br_wait               FSM is waiting for a control transfer to resolve
module de_issue_stage #(
    parameter int XLEN      = 64,
    parameter int NUM_FWD   = 3,
    parameter int CTRL_WAIT = 1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    de_v,
    input  logic [31:0]             de_ir,
    input  logic [XLEN-1:0]         de_npc,
    input  logic [XLEN-1:0]         de_imm,
    input  logic [XLEN-1:0]         rf_rs1_data,
    input  logic [XLEN-1:0]         rf_rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_v,
    input  logic [5*NUM_FWD-1:0]    fwd_drid,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]      fwd_is_load,
    input  logic                    br_resolve,
    input  logic                    flush,
    input  logic                    ds_stall,
    output logic                    exe_v,
    output logic [31:0]             exe_ir,
    output logic [XLEN-1:0]         exe_npc,
    output logic [XLEN-1:0]         exe_op1,
    output logic [XLEN-1:0]         exe_op2,
    output logic [XLEN-1:0]         exe_rs2_val,
    output logic                    de_stall,
    output logic                    br_wait
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [31:0] NOP_IR   = 32'h0000_0013;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [4:0] rs1_id, rs2_id;
    logic       rs1_used, rs2_used, op2_is_rs2, is_ctrl;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            rs1_ld, rs2_ld;
    logic            hazard, issue;

    logic            exe_v_q;
    logic [31:0]     exe_ir_q;
    logic [XLEN-1:0] exe_npc_q, exe_op1_q, exe_op2_q, exe_rs2_q;

    assign opcode = de_ir[6:0];
    assign rs1_id = de_ir[19:15];
    assign rs2_id = de_ir[24:20];

    assign rs1_used   = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign rs2_used   = opcode inside {OP_REG, OP_REG32, OP_STORE, OP_BRANCH};
    assign op2_is_rs2 = opcode inside {OP_REG, OP_REG32, OP_BRANCH};
    assign is_ctrl    = opcode inside {OP_BRANCH, OP_JAL, OP_JALR};

    // Walk from oldest to youngest so a younger match overwrites an older one.
    // The load flag follows the same winner, so a younger non-load match
    // hides an older load to the same register.
    always_comb begin
        rs1_fwd = rf_rs1_data;
        rs2_fwd = rf_rs2_data;
        rs1_ld  = 1'b0;
        rs2_ld  = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_v[k] && (fwd_drid[5*k +: 5] == rs1_id) && (rs1_id != 5'd0)) begin
                rs1_fwd = fwd_data[XLEN*k +: XLEN];
                rs1_ld  = fwd_is_load[k];
            end
            if (fwd_v[k] && (fwd_drid[5*k +: 5] == rs2_id) && (rs2_id != 5'd0)) begin
                rs2_fwd = fwd_data[XLEN*k +: XLEN];
                rs2_ld  = fwd_is_load[k];
            end
        end
    end

    assign hazard = (rs1_used && rs1_ld) || (rs2_used && rs2_ld);
    assign issue  = de_v && !hazard && (state_q == IDLE) && !ds_stall && !flush;

    assign de_stall = (de_v && hazard) || (state_q == BR_WAIT) || ds_stall;
    assign br_wait  = (state_q == BR_WAIT);

    // Control-transfer wait FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((CTRL_WAIT != 0) && issue && is_ctrl) begin
                    state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolve || flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DE -> EXE pipeline register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            exe_v_q   <= 1'b0;
            exe_ir_q  <= '0;
            exe_npc_q <= '0;
            exe_op1_q <= '0;
            exe_op2_q <= '0;
            exe_rs2_q <= '0;
        end else if (flush) begin
            exe_v_q <= 1'b0;
        end else if (ds_stall) begin
            exe_v_q <= exe_v_q;
        end else if (issue) begin
            exe_v_q   <= 1'b1;
            exe_ir_q  <= de_ir;
            exe_npc_q <= de_npc;
            exe_op1_q <= rs1_fwd;
            exe_op2_q <= op2_is_rs2 ? rs2_fwd : de_imm;
            exe_rs2_q <= rs2_fwd;
        end else begin
            // A bubble carries a NOP so EXE decodes nothing meaningful.
            exe_v_q  <= 1'b0;
            exe_ir_q <= NOP_IR;
        end
    end

    assign exe_v       = exe_v_q;
    assign exe_ir      = exe_ir_q;
    assign exe_npc     = exe_npc_q;
    assign exe_op1     = exe_op1_q;
    assign exe_op2     = exe_op2_q;
    assign exe_rs2_val = exe_rs2_q;

endmodule

// File: tb/tb_de_issue_stage.sv
module tb_de_issue_stage;

    localparam int XLEN = 64;
    localparam int NF   = 3;
    localparam int CW   = 1;

    logic                 CLK;
    logic                 reset;
    logic                 de_v;
    logic [31:0]          de_ir;
    logic [XLEN-1:0]      de_npc, de_imm, rf_rs1_data, rf_rs2_data;
    logic [NF-1:0]        fwd_v, fwd_is_load;
    logic [5*NF-1:0]      fwd_drid;
    logic [XLEN*NF-1:0]   fwd_data;
    logic                 br_resolve, flush, ds_stall;
    logic                 exe_v;
    logic [31:0]          exe_ir;
    logic [XLEN-1:0]      exe_npc, exe_op1, exe_op2, exe_rs2_val;
    logic                 de_stall, br_wait;

    int tests = 0;
    int fails = 0;

    // Reference model state: what EXE should hold and whether we wait on a branch.
    logic            m_v;
    logic [31:0]     m_ir;
    logic [XLEN-1:0] m_npc, m_op1, m_op2, m_rs2;
    logic            m_bw;

    logic [6:0] op_tab [10] = '{7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011, 7'b0010011,
                                7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    de_issue_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CTRL_WAIT(CW)) dut (
        .CLK(CLK), .reset(reset),
        .de_v(de_v), .de_ir(de_ir), .de_npc(de_npc), .de_imm(de_imm),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .fwd_v(fwd_v), .fwd_drid(fwd_drid), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
        .br_resolve(br_resolve), .flush(flush), .ds_stall(ds_stall),
        .exe_v(exe_v), .exe_ir(exe_ir), .exe_npc(exe_npc), .exe_op1(exe_op1),
        .exe_op2(exe_op2), .exe_rs2_val(exe_rs2_val),
        .de_stall(de_stall), .br_wait(br_wait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Youngest valid source writing register r supplies the value; x0 never forwards.
    task automatic lookup(input logic [4:0] r, input logic [XLEN-1:0] rfv,
                          output logic [XLEN-1:0] val, output logic ld);
        val = rfv;
        ld  = 1'b0;
        if (r != 5'd0) begin
            for (int k = 0; k < NF; k++) begin
                if (fwd_v[k] && fwd_drid[5*k +: 5] == r) begin
                    val = fwd_data[XLEN*k +: XLEN];
                    ld  = fwd_is_load[k];
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_v = 0; m_ir = '0; m_npc = '0; m_op1 = '0; m_op2 = '0; m_rs2 = '0; m_bw = 0;
    endtask

    task automatic idle_inputs();
        de_v = 0; de_ir = 32'h13; de_npc = '0; de_imm = '0;
        rf_rs1_data = '0; rf_rs2_data = '0;
        fwd_v = '0; fwd_drid = '0; fwd_data = '0; fwd_is_load = '0;
        br_resolve = 0; flush = 0; ds_stall = 0;
    endtask

    // One clock: check combinational outputs, advance model, check EXE after the edge.
    task automatic step();
        logic [6:0] op;
        logic [XLEN-1:0] v1, v2;
        logic l1, l2, use1, use2, haz, go, exp_stall;
        #2;
        op   = de_ir[6:0];
        use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        use2 = op inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
        lookup(de_ir[19:15], rf_rs1_data, v1, l1);
        lookup(de_ir[24:20], rf_rs2_data, v2, l2);
        haz = (use1 && l1) || (use2 && l2);
        exp_stall = (de_v && haz) || m_bw || ds_stall;
        chk("de_stall", de_stall, exp_stall);
        chk("br_wait", br_wait, m_bw);
        go = de_v && !haz && !m_bw && !ds_stall && !flush;
        if (flush) m_v = 0;
        else if (ds_stall) m_v = m_v;
        else if (go) begin
            m_v = 1; m_ir = de_ir; m_npc = de_npc; m_op1 = v1; m_rs2 = v2;
            m_op2 = (op inside {7'b0110011, 7'b0111011, 7'b1100011}) ? v2 : de_imm;
        end else begin
            m_v = 0; m_ir = 32'h13;
        end
        if (m_bw) begin
            if (br_resolve || flush) m_bw = 0;
        end else if (CW != 0 && go && (op inside {7'b1100011, 7'b1101111, 7'b1100111})) begin
            m_bw = 1;
        end
        @(posedge CLK);
        #1;
        chk("exe_v", exe_v, m_v);
        chk("exe_ir", exe_ir, m_ir);
        if (m_v) begin
            chk("exe_npc", exe_npc, m_npc);
            chk("exe_op1", exe_op1, m_op1);
            chk("exe_op2", exe_op2, m_op2);
            chk("exe_rs2_val", exe_rs2_val, m_rs2);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_v"}, exe_v, 0);
        chk({tag, "_ir"}, exe_ir, 0);
        chk({tag, "_npc"}, exe_npc, 0);
        chk({tag, "_op1"}, exe_op1, 0);
        chk({tag, "_op2"}, exe_op2, 0);
        chk({tag, "_rs2"}, exe_rs2_val, 0);
        chk({tag, "_stall"}, de_stall, 0);
        chk({tag, "_bw"}, br_wait, 0);
    endtask

    logic [XLEN-1:0] A, B;
    logic [4:0] ra, rb, rd;

    initial begin
        A = 64'hA5A5_0000_1111_2222;
        B = 64'h5A5A_FFFF_3333_4444;
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_all_zero("rst");
        @(posedge CLK); @(posedge CLK); #1;
        reset = 1'b1;

        // 1. Forwarding priority: source 0 beats source 2 for x5.
        de_v = 1; de_ir = 32'h005280B3; de_npc = 64'h1004;
        rf_rs1_data = 64'hDEAD; rf_rs2_data = 64'hBEEF;
        fwd_v = 3'b101; fwd_drid = {5'd5, 5'd0, 5'd5}; fwd_data = {B, 64'h0, A};
        step();
        chk("t1_v", exe_v, 1);
        chk("t1_op1", exe_op1, A);
        chk("t1_op2", exe_op2, A);

        // 2. x0 never forwarded.
        de_ir = 32'h00700093; de_imm = 64'd7; rf_rs1_data = '0;
        fwd_v = 3'b111; fwd_drid = '0; fwd_data = {B, B, A};
        step();
        chk("t2_op1", exe_op1, 0);
        chk("t2_op2", exe_op2, 7);

        // 3. Load-use hazard, then release.
        de_ir = 32'h005280B3;
        fwd_v = 3'b001; fwd_drid = {5'd0, 5'd0, 5'd5}; fwd_data = {B, B, A}; fwd_is_load = 3'b001;
        #1 chk("t3_stall", de_stall, 1);
        step();
        chk("t3_bub_v", exe_v, 0);
        chk("t3_bub_ir", exe_ir, 32'h13);
        fwd_is_load = 3'b000;
        step();
        chk("t3_v", exe_v, 1);
        chk("t3_op1", exe_op1, A);

        // 4. Branch wait.
        idle_inputs();
        de_v = 1; de_ir = 32'h00208063; de_npc = 64'h2000;
        step();
        chk("t4_bv", exe_v, 1);
        chk("t4_bw", br_wait, 1);
        de_ir = 32'h00700093; de_imm = 64'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_wait_v", exe_v, 0);
            chk("t4_wait_bw", br_wait, 1);
            chk("t4_wait_stall", de_stall, 1);
        end
        br_resolve = 1;
        step();
        chk("t4_idle", br_wait, 0);
        br_resolve = 0;
        step();
        chk("t4_issue", exe_v, 1);
        chk("t4_issue_ir", exe_ir, 32'h00700093);

        // 5. Downstream hold, then flush beats ds_stall.
        de_ir = 32'h00A00113; de_imm = 64'd10;
        ds_stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5_hold_v", exe_v, 1);
            chk("t5_hold_ir", exe_ir, 32'h00700093);
        end
        flush = 1;
        step();
        chk("t5_flush_v", exe_v, 0);
        flush = 0; ds_stall = 0;

        // 6. Asynchronous reset in BR_WAIT.
        de_ir = 32'h00208063;
        step();
        chk("t6_bw", br_wait, 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("t6_rst");
        model_reset();
        @(posedge CLK); #1;
        reset = 1'b1;
        de_ir = 32'h00700093; de_imm = 64'd7;
        step();
        chk("t6_issue", exe_v, 1);
        chk("t6_issue_op2", exe_op2, 7);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ra = 5'($urandom_range(0, 3));
            rb = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 31));
            de_v = ($urandom_range(0, 3) != 0);
            de_ir = {7'($urandom), rb, ra, 3'($urandom), rd, op_tab[$urandom_range(0, 9)]};
            de_npc = {$urandom, $urandom};
            de_imm = {$urandom, $urandom};
            rf_rs1_data = {$urandom, $urandom};
            rf_rs2_data = {$urandom, $urandom};
            fwd_v = 3'($urandom);
            for (int k = 0; k < NF; k++) begin
                fwd_drid[5*k +: 5] = 5'($urandom_range(0, 3));
                fwd_data[XLEN*k +: XLEN] = {$urandom, $urandom};
                fwd_is_load[k] = ($urandom_range(0, 5) == 0);
            end
            br_resolve = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            ds_stall = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
